lcd_write_arbiter: RTL and testbench

Write-only sequencer and arbiter for the character LCD port (`lcd_read_write`, `lcd_register_select`, `lcd_enable_op`, `lcd_data_out`). It runs the power-on initialisation of the HD44780-style controller. After that it shares the LCD between two requesters: port 0 is the score/status writer and port 1 is the processor writer. It turns each accepted byte into a correctly timed enable pulse, followed by a command-execution wait.

---
 rtl/lcd_write_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
// Write-only HD44780 sequencer: runs the power-on init, then round-robin arbitrates
// two byte requesters onto the LCD with timed setup/enable/hold/execute phases.
module lcd_write_arbiter #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned PULSE_CYC     = 12,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned LONG_EXEC_CYC = 82000,
  parameter int unsigned INIT_WAIT_CYC = 750000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       p0_valid,
  input  logic       p0_rs,
  input  logic [7:0] p0_data,
  output logic       p0_ready,
  input  logic       p1_valid,
  input  logic       p1_rs,
  input  logic [7:0] p1_data,
  output logic       p1_ready,
  output logic       lcd_read_write,
  output logic       lcd_register_select,
  output logic       lcd_enable_op,
  output logic [7:0] lcd_data_out,
  output logic       init_done,
  output logic       busy
);

  localparam int unsigned MAX_CYC = (INIT_WAIT_CYC > LONG_EXEC_CYC) ? INIT_WAIT_CYC : LONG_EXEC_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned IDX_W   = 2;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                last_q, last_d;
  logic                rs_q, rs_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                e_q;
  logic                busy_q;

  logic                cnt_zero;
  logic                grant;
  logic                idle_ok;
  logic                is_long;

  // Function-set, display-on, clear, entry-mode
  function automatic logic [DATA_W-1:0] init_cmd(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  assign cnt_zero = (cnt_q == '0);
  assign grant    = (p0_valid && p1_valid) ? ~last_q : p1_valid;
  assign idle_ok  = (state_q == ST_IDLE) && done_q;
  assign p0_ready = idle_ok && p0_valid && !grant;
  assign p1_ready = idle_ok && p1_valid && grant;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait
  assign is_long = !rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'h00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : (cnt_q - CNT_W'(1));
    idx_d   = idx_q;
    last_d  = last_q;
    rs_d    = rs_q;
    data_d  = data_q;
    done_d  = done_q;
    case (state_q)
      ST_POWERUP: begin
        if (cnt_zero) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          rs_d    = 1'b0;
          data_d  = init_cmd(idx_q);
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_EXEC;
          cnt_d   = is_long ? LONG_LD : EXEC_LD;
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          if (done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            idx_d   = idx_q + 2'd1;
            rs_d    = 1'b0;
            data_d  = init_cmd(idx_q + 2'd1);
          end
        end
      end
      ST_IDLE: begin
        if (p0_ready || p1_ready) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          last_d  = grant;
          rs_d    = grant ? p1_rs : p0_rs;
          data_d  = grant ? p1_data : p0_data;
        end
      end
      default: begin
        state_d = ST_POWERUP;
        cnt_d   = INIT_LD;
      end
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= ST_POWERUP;
      cnt_q   <= INIT_LD;
      idx_q   <= '0;
      last_q  <= 1'b1;
      rs_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      done_q  <= done_d;
      e_q     <= (state_d == ST_PULSE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign lcd_read_write      = 1'b0;
  assign lcd_register_select = rs_q;
  assign lcd_data_out        = data_q;
  assign lcd_enable_op       = e_q;
  assign init_done           = done_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: init sequence, vector table of single writes,
// round-robin tie, requests during init and reset in the middle of an enable pulse.
module tb_lcd_write_arbiter;

  localparam int S    = 1;
  localparam int P    = 3;
  localparam int H    = 1;
  localparam int X    = 4;
  localparam int LONG = 10;
  localparam int INIT = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p0_valid = 1'b0, p0_rs = 1'b0;
  logic [7:0] p0_data = 8'h00;
  logic       p1_valid = 1'b0, p1_rs = 1'b0;
  logic [7:0] p1_data = 8'h00;
  logic       p0_ready, p1_ready;
  logic       lcd_read_write, lcd_register_select, lcd_enable_op;
  logic [7:0] lcd_data_out;
  logic       init_done, busy;

  int checks = 0;
  int errors = 0;
  int rw_bad = 0;
  int overlap = 0;

  logic [8:0] pq[$];
  int         gq[$];
  bit         e_prev = 1'b0;
  bit         in_gap = 1'b0;
  int         run = 0;
  int         gap_cnt = 0;

  typedef struct {
    bit         v0;
    bit         rs0;
    logic [7:0] d0;
    bit         v1;
    bit         rs1;
    logic [7:0] d1;
    int         port;
    logic [8:0] exp_out;
    int         exp_x;
  } vec_t;

  vec_t vecs[8];

  lcd_write_arbiter #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
    .EXEC_CYC(X), .LONG_EXEC_CYC(LONG), .INIT_WAIT_CYC(INIT)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .p0_valid(p0_valid),
    .p0_rs(p0_rs),
    .p0_data(p0_data),
    .p0_ready(p0_ready),
    .p1_valid(p1_valid),
    .p1_rs(p1_rs),
    .p1_data(p1_data),
    .p1_ready(p1_ready),
    .lcd_read_write(lcd_read_write),
    .lcd_register_select(lcd_register_select),
    .lcd_enable_op(lcd_enable_op),
    .lcd_data_out(lcd_data_out),
    .init_done(init_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse monitor: records {rs,data} at each E rise, pulse widths and E-low gaps
  always @(posedge clk) begin
    #1;
    if (rst) begin
      e_prev = 1'b0;
      in_gap = 1'b0;
      run    = 0;
    end else begin
      if (lcd_read_write) rw_bad++;
      if (lcd_enable_op && !e_prev) begin
        pq.push_back({lcd_register_select, lcd_data_out});
        run = 1;
        if (in_gap) begin
          gq.push_back(gap_cnt);
          in_gap = 1'b0;
        end
      end else if (lcd_enable_op) begin
        run++;
      end else if (e_prev) begin
        chk("pulse_width", run, P);
        in_gap  = 1'b1;
        gap_cnt = 1;
      end else if (in_gap) begin
        if (busy) gap_cnt++;
        else begin
          gq.push_back(gap_cnt);
          in_gap = 1'b0;
        end
      end
      e_prev = lcd_enable_op;
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && p0_ready && p1_ready) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drop_valids();
    p0_valid = 1'b0;
    p1_valid = 1'b0;
  endtask

  // Release reset and check the full init sequence, then the pending request on `port`
  task automatic do_init(input int port, input logic [7:0] d);
    int  n;
    int  early;
    bit  done;
    bit  rdy;
    int  exp_gap[4];
    logic [8:0] exp_cmd[4];
    exp_cmd = '{9'h038, 9'h00C, 9'h001, 9'h006};
    exp_gap = '{H + X + S, H + X + S, H + LONG + S, H + X};
    pq.delete();
    gq.delete();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (lcd_enable_op) done = 1'b1;
    end
    chk("init_first_rise", n, INIT + S);
    n = 0;
    early = 0;
    done = 1'b0;
    rdy = 1'b0;
    while (!done && n < 500) begin
      @(negedge clk); #1;
      n++;
      rdy = (port == 1) ? p1_ready : p0_ready;
      if (init_done) done = 1'b1;
      else if (rdy) early++;
    end
    chk("ready_before_init", early, 0);
    chk("init_done_set", int'(init_done), 1);
    chk("ready_first_idle", int'(rdy), 1);
    chk("busy_first_idle", int'(busy), 0);
    @(posedge clk); #1;
    drop_valids();
    n = 0;
    while (pq.size() < 5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("init_pulse_count", pq.size(), 5);
    if (pq.size() >= 5) begin
      for (int i = 0; i < 4; i++) chk($sformatf("init_cmd%0d", i), int'(pq[i]), int'(exp_cmd[i]));
      chk("init_req_byte", int'(pq[4]), int'({1'b1, d}));
    end
    if (gq.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("init_gap%0d", i), gq[i], exp_gap[i]);
    end else chk("init_gap_count", gq.size(), 4);
    repeat (30) @(posedge clk);
    #1;
    chk("written_once", pq.size(), 5);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int k;
    int rise;
    int idle;
    int got;
    pq.delete();
    @(negedge clk);
    p0_valid = v.v0; p0_rs = v.rs0; p0_data = v.d0;
    p1_valid = v.v1; p1_rs = v.rs1; p1_data = v.d1;
    #1;
    n = 0;
    while (!(p0_ready || p1_ready) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    got = p1_ready ? 1 : (p0_ready ? 0 : -1);
    chk($sformatf("v%0d_grant", idx), got, v.port);
    k = 0; rise = 0; idle = 0;
    while (idle == 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        chk($sformatf("v%0d_out_t1", idx), int'({lcd_register_select, lcd_data_out}), int'(v.exp_out));
        chk($sformatf("v%0d_busy_t1", idx), int'(busy), 1);
        drop_valids();
      end
      if (lcd_enable_op && rise == 0) rise = k;
      if (!busy) idle = k;
    end
    chk($sformatf("v%0d_e_rise", idx), rise, S + 1);
    chk($sformatf("v%0d_idle", idx), idle, S + P + H + v.exp_x + 1);
    chk($sformatf("v%0d_pulses", idx), pq.size(), 1);
    if (pq.size() > 0) chk($sformatf("v%0d_lcd_byte", idx), int'(pq[0]), int'(v.exp_out));
  endtask

  initial begin
    int n;
    logic [8:0] tie_exp[4];

    // Phase 1: reset values, then init with p0 already requesting
    rst = 1'b1;
    p0_valid = 1'b1; p0_rs = 1'b1; p0_data = 8'h55;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_e", int'(lcd_enable_op), 0);
    chk("rst_rs", int'(lcd_register_select), 0);
    chk("rst_data", int'(lcd_data_out), 0);
    chk("rst_rw", int'(lcd_read_write), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_p0_ready", int'(p0_ready), 0);
    chk("rst_p1_ready", int'(p1_ready), 0);
    do_init(0, 8'h55);

    // Phase 2: single writes, long-command detection, one arbitrated tie
    vecs[0] = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 0, 9'h141, X};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1, 9'h001, LONG};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1, 9'h003, LONG};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1, 9'h004, X};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1, 9'h101, X};
    vecs[5] = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 0, 9'h002, LONG};
    vecs[6] = '{1'b1, 1'b1, 8'h50, 1'b1, 1'b1, 8'h60, 1, 9'h160, X};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1, 9'h000, X};
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Phase 3: both held valid, bytes must alternate starting with p0
    tie_exp = '{9'h131, 9'h132, 9'h131, 9'h132};
    pq.delete();
    @(negedge clk);
    p0_valid = 1'b1; p0_rs = 1'b1; p0_data = 8'h31;
    p1_valid = 1'b1; p1_rs = 1'b1; p1_data = 8'h32;
    n = 0;
    while (pq.size() < 4 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    drop_valids();
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tie_pulses", pq.size(), 4);
    if (pq.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("tie_byte%0d", i), int'(pq[i]), int'(tie_exp[i]));
    end

    // Phase 4: reset while E is high; p1 keeps its request through the restart
    @(negedge clk);
    p1_valid = 1'b1; p1_rs = 1'b1; p1_data = 8'h77;
    n = 0;
    while (!lcd_enable_op && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_e_high", int'(lcd_enable_op), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_e", int'(lcd_enable_op), 0);
    chk("mid_rst_init_done", int'(init_done), 0);
    chk("mid_rst_busy", int'(busy), 1);
    repeat (2) @(negedge clk);
    do_init(1, 8'h77);

    chk("rw_always_zero", rw_bad, 0);
    chk("ready_one_hot", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
